ifetch_unit: RTL and testbench

//   Instruction-fetch initiator for the pipelined MIPS core. It owns the PC and

---
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: owns the PC, reads the combinational ROM, and
// queues fetched words in a small FIFO that feeds decode over valid/ready.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [23:0] ROM_BASE  = 24'h000000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [31:0]      pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic [31:0]      buf_pc    [BUF_DEPTH];

  logic pc_ok;
  logic pop;
  logic push;
  logic fault_set;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign pc_ok     = (pc[1:0] == 2'b00) && (pc[31:8] == ROM_BASE);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && !fetch_fault && pc_ok &&
                     ((count < DEPTH_C) || pop);
  assign fault_set = !fetch_fault && !redirect_valid && !pc_ok;

  assign imem_addr = pc;
  assign out_instr = buf_instr[head];
  assign out_pc    = buf_pc[head];

  // Redirect outranks everything; a pending fault freezes the PC until a redirect or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (push) begin
        pc <= pc + 32'd4;
      end
      if (fault_set) begin
        fetch_fault <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first fetch lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (push) begin
      buf_instr[tail] <= imem_data;
      buf_pc[tail]    <= pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, backpressure, redirect, faults,
// ROM-window end and asynchronous reset, against a small combinational ROM.
module tb_ifetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int checks = 0;
  int passes = 0;

  ifetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h8C02_0004;
      32'h04:  return 32'h0042_1020;
      32'h08:  return 32'h0800_0007;
      32'h0C:  return 32'h0022_1820;
      32'h1C:  return 32'h0042_1020;
      32'h20:  return 32'hAC02_0008;
      default: return {8'hEE, a[23:0]};
    endcase
  endfunction

  always_comb imem_data = rom_word(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // T1: reset values, then a one-per-cycle stream
    step();
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'h0);
    applyReset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t1_valid0", {31'b0, out_valid}, 32'h1);
    checkOutput("t1_pc0", out_pc, 32'h0);
    checkOutput("t1_instr0", out_instr, 32'h8C02_0004);
    checkOutput("t1_addr0", imem_addr, 32'h4);
    step();
    checkOutput("t1_pc1", out_pc, 32'h4);
    checkOutput("t1_instr1", out_instr, 32'h0042_1020);
    step();
    checkOutput("t1_pc2", out_pc, 32'h8);
    checkOutput("t1_instr2", out_instr, 32'h0800_0007);

    // T2: backpressure for 5 cycles, then drain in order
    applyReset();
    for (int i = 0; i < 5; i++) step();
    checkOutput("t2_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("t2_head_pc", out_pc, 32'h0);
    checkOutput("t2_addr_hold", imem_addr, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t2_pc4", out_pc, 32'h4);
    checkOutput("t2_instr4", out_instr, 32'h0042_1020);
    step();
    checkOutput("t2_pc8", out_pc, 32'h8);
    step();
    checkOutput("t2_pcC", out_pc, 32'hC);
    checkOutput("t2_instrC", out_instr, 32'h0022_1820);

    // T3: redirect with two entries buffered
    applyReset();
    step();
    step();
    applyStimulus(1'b1, 32'h1C, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_flush_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("t3_addr", imem_addr, 32'h1C);
    step();
    checkOutput("t3_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("t3_pc1C", out_pc, 32'h1C);
    checkOutput("t3_instr1C", out_instr, 32'h0042_1020);
    step();
    checkOutput("t3_pc20", out_pc, 32'h20);
    checkOutput("t3_instr20", out_instr, 32'hAC02_0008);

    // T4: misaligned redirect target raises a sticky fault
    applyStimulus(1'b1, 32'h1E, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4_fault_early", {31'b0, fetch_fault}, 32'h0);
    step();
    checkOutput("t4_fault", {31'b0, fetch_fault}, 32'h1);
    checkOutput("t4_valid", {31'b0, out_valid}, 32'h0);
    step();
    step();
    checkOutput("t4_addr_hold", imem_addr, 32'h1E);
    checkOutput("t4_valid_late", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t4_redir_addr", imem_addr, 32'h0);
    checkOutput("t4_no_fetch", {31'b0, out_valid}, 32'h0);
    checkOutput("t4_fault_sticky", {31'b0, fetch_fault}, 32'h1);

    // T5: run off the end of the ROM window
    applyReset();
    applyStimulus(1'b1, 32'hF8, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t5_pcF8", out_pc, 32'hF8);
    checkOutput("t5_instrF8", out_instr, 32'hEE00_00F8);
    step();
    checkOutput("t5_pcFC", out_pc, 32'hFC);
    checkOutput("t5_validFC", {31'b0, out_valid}, 32'h1);
    step();
    checkOutput("t5_fault", {31'b0, fetch_fault}, 32'h1);
    checkOutput("t5_valid_end", {31'b0, out_valid}, 32'h0);
    checkOutput("t5_addr", imem_addr, 32'h100);
    step();
    checkOutput("t5_valid_stays", {31'b0, out_valid}, 32'h0);

    // T6: asynchronous reset between edges with a buffered word and a fault
    applyReset();
    applyStimulus(1'b1, 32'hFC, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    step();
    checkOutput("t6_pre_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("t6_pre_fault", {31'b0, fetch_fault}, 32'h1);
    checkOutput("t6_pre_pc", out_pc, 32'hFC);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("t6_async_fault", {31'b0, fetch_fault}, 32'h0);
    checkOutput("t6_async_addr", imem_addr, 32'h0);
    checkOutput("t6_async_pc", out_pc, 32'h0);
    step();
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t6_restart_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("t6_restart_pc", out_pc, 32'h0);
    checkOutput("t6_restart_instr", out_instr, 32'h8C02_0004);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
